uart_rx: RTL and testbench

UART receiver paired with the team's UART transmitter. It runs on an oversampling clock (PRESCALE ticks per bit) and detects the start bit, then recovers an LSB-first data word, an optional parity bit and one stop bit. It presents the word on P_DATA with a single-cycle Data_Valid pulse and flags parity and framing errors. It sits between the external serial line (already synchronized to CLK upstream) and the parallel consumer.

---
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Port bundle for the UART receiver. It carries the serial
//               line and frame configuration from the line side to the
//               receiver, and carries the received word and status flags
//               back from the receiver to the consumer.
//   master : drives RX_IN, PRESCALE, PAR_EN, PAR_TYP; observes P_DATA,
//            Data_Valid, par_err, stop_err
//   slave  : the receiver itself (the opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic                    RX_IN;
    logic [5:0]              PRESCALE;
    logic                    PAR_EN;
    logic                    PAR_TYP;
    logic [P_DATA_WIDTH-1:0] P_DATA;
    logic                    Data_Valid;
    logic                    par_err;
    logic                    stop_err;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stop_err
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stop_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. It detects a start bit, then
//               recovers an LSB-first data word, an optional parity bit and
//               one stop bit. A good frame updates P_DATA with a one-cycle
//               Data_Valid pulse. Parity and framing errors are flagged and
//               stay set until the next start detection.
// Ports       : CLK        - oversampling clock (PRESCALE ticks per bit)
//               RST        - synchronous reset, active low
//               bus.slave  - RX_IN, PRESCALE, PAR_EN, PAR_TYP in;
//                            P_DATA, Data_Valid, par_err, stop_err out
// Options     : UART_RX_MAJORITY_VOTE_EN - 2-of-3 vote around mid-bit
//               instead of a single sample at mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int P_DATA_WIDTH = 8
) (
    input  wire logic CLK,
    input  wire logic RST,
    uart_rx_if.slave  bus
);

    localparam int BCW = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] c_LAST_BIT = BCW'(P_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [5:0]              edge_cnt_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic [P_DATA_WIDTH-1:0] shift_q;
    logic [P_DATA_WIDTH-1:0] p_data_q;
    logic                    dv_q;
    logic                    par_err_q;
    logic                    stop_err_q;
    logic                    par_en_q;
    logic                    par_typ_q;

    logic [5:0]              w_mid;
    logic                    w_last;
    logic                    w_dec;
    logic                    w_bit;
    logic                    w_par_exp;
    logic [P_DATA_WIDTH:0]   w_shift_ext;

    assign w_mid       = {1'b0, bus.PRESCALE[5:1]};
    assign w_last      = (edge_cnt_q == (bus.PRESCALE - 6'd1));
    assign w_par_exp   = (^shift_q) ^ par_typ_q;
    // New bit enters at the MSB; after the last bit the first bit is at LSB.
    assign w_shift_ext = {w_bit, shift_q};

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Samples at mid-1 and mid; the third vote is the live input at mid+1,
    // so the decision edge moves to mid+1 while bit boundaries stay put.
    logic [1:0] vote_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            vote_q <= 2'b00;
        end else begin
            if (edge_cnt_q == (w_mid - 6'd1)) vote_q[0] <= bus.RX_IN;
            if (edge_cnt_q == w_mid)          vote_q[1] <= bus.RX_IN;
        end
    end

    assign w_dec = (edge_cnt_q == (w_mid + 6'd1));
    assign w_bit = (vote_q[0] & vote_q[1]) |
                   (vote_q[0] & bus.RX_IN) |
                   (vote_q[1] & bus.RX_IN);
`else
    assign w_dec = (edge_cnt_q == w_mid);
    assign w_bit = bus.RX_IN;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    edge_cnt_q <= 6'd0;
                    bit_cnt_q  <= '0;
                    if (!bus.RX_IN) begin
                        // The detect cycle counts as tick 0 of the start bit.
                        state_q    <= S_START;
                        edge_cnt_q <= 6'd1;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_dec && w_bit) begin
                        // Line went back high by mid-bit: treat as a glitch.
                        state_q    <= S_IDLE;
                        edge_cnt_q <= 6'd0;
                    end else if (w_last) begin
                        state_q    <= S_DATA;
                        edge_cnt_q <= 6'd0;
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end

                S_DATA: begin
                    if (w_dec) shift_q <= w_shift_ext[P_DATA_WIDTH:1];
                    if (w_last) begin
                        edge_cnt_q <= 6'd0;
                        if (bit_cnt_q == c_LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end

                S_PARITY: begin
                    if (w_dec && (w_bit != w_par_exp)) par_err_q <= 1'b1;
                    if (w_last) begin
                        state_q    <= S_STOP;
                        edge_cnt_q <= 6'd0;
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end

                S_STOP: begin
                    if (w_dec && !w_bit) stop_err_q <= 1'b1;
                    if (w_last) begin
                        state_q    <= S_IDLE;
                        edge_cnt_q <= 6'd0;
                        // Stop decision precedes the last tick, so both
                        // flags already reflect this frame here.
                        if (!par_err_q && !stop_err_q) begin
                            p_data_q <= shift_q;
                            dv_q     <= 1'b1;
                        end
                    end else begin
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    edge_cnt_q <= 6'd0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.Data_Valid = dv_q;
    assign bus.par_err    = par_err_q;
    assign bus.stop_err   = stop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are driven bit by
//               bit; good frames push {word, expected Data_Valid cycle} to a
//               scoreboard that a negedge monitor pops on each Data_Valid.
//               Error flags and held data are checked at the end of frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic prev_dv;
    logic [7:0] last_good;
    exp_t sb_q[$];

    uart_rx_if #(.P_DATA_WIDTH(8)) ifc ();

    uart_rx #(.P_DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Output monitor: every Data_Valid must match the oldest expected frame
    // in both data and cycle, and never repeat on consecutive cycles.
    initial prev_dv = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ifc.Data_Valid === 1'b1) begin
            check("dv_gap", {31'd0, prev_dv}, 32'd0);
            if (sb_q.size() == 0) begin
                check("dv_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("p_data", {24'd0, ifc.P_DATA}, {24'd0, e.d});
                check("dv_time", cyc, e.t);
            end
        end
        prev_dv = ifc.Data_Valid;
    end

    // All drivers are entered and left #1 after a rising edge.
    task automatic idle(input int n);
        ifc.RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one bit for PRESCALE ticks; optionally invert it for the single
    // tick that lands on the mid-bit sample.
    task automatic drive_bit(input logic b, input bit glitch);
        int p;
        int mid;
        p   = int'(ifc.PRESCALE);
        mid = p / 2;
        ifc.RX_IN = b;
        if (glitch) begin
            repeat (mid) @(posedge clk);
            #1 ifc.RX_IN = ~b;
            @(posedge clk);
            #1 ifc.RX_IN = b;
            repeat (p - mid - 1) @(posedge clk);
        end else begin
            repeat (p) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par,
                              input logic stop_val, input int glitch_bit);
        int   p;
        int   f;
        bit   pe;
        bit   bad;
        logic pbit;
        p    = int'(ifc.PRESCALE);
        pe   = ifc.PAR_EN;
        f    = 10 + (pe ? 1 : 0);
        pbit = (^d) ^ ifc.PAR_TYP ^ flip_par;
        bad  = (pe && flip_par) || !stop_val;
        if (!bad) sb_q.push_back('{d: d, t: cyc + f * p});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
        if (pe) drive_bit(pbit, 1'b0);
        drive_bit(stop_val, 1'b0);
        ifc.RX_IN = 1'b1;
        check("par_err", {31'd0, ifc.par_err}, {31'd0, pe && flip_par});
        check("stop_err", {31'd0, ifc.stop_err}, {31'd0, !stop_val});
        check("dv_at_end", {31'd0, ifc.Data_Valid}, {31'd0, !bad});
        if (bad) check("p_data_hold", {24'd0, ifc.P_DATA}, {24'd0, last_good});
        else     last_good = d;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_p_data"}, {24'd0, ifc.P_DATA}, 32'd0);
        check({tag, "_dv"}, {31'd0, ifc.Data_Valid}, 32'd0);
        check({tag, "_par_err"}, {31'd0, ifc.par_err}, 32'd0);
        check({tag, "_stop_err"}, {31'd0, ifc.stop_err}, 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        last_good    = 8'h00;
        rst_n        = 1'b0;
        ifc.RX_IN    = 1'b1;
        ifc.PRESCALE = 6'd8;
        ifc.PAR_EN   = 1'b0;
        ifc.PAR_TYP  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        idle(5);

        // Basic frame, no parity, fastest legal prescale.
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(3);

        // Even parity: correct then corrupted parity bit.
        ifc.PRESCALE = 6'd16;
        ifc.PAR_EN   = 1'b1;
        ifc.PAR_TYP  = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(4);

        // Odd parity: framing error, then a good frame clears the flag.
        ifc.PRESCALE = 6'd32;
        ifc.PAR_TYP  = 1'b1;
        send_frame(8'h00, 1'b0, 1'b0, -1);
        idle(6);
        send_frame(8'h81, 1'b0, 1'b1, -1);
        idle(4);

        // Short low pulse is rejected as a false start.
        ifc.PRESCALE = 6'd16;
        ifc.PAR_EN   = 1'b0;
        ifc.RX_IN    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(40);
        check("glitch_par_err", {31'd0, ifc.par_err}, 32'd0);
        check("glitch_stop_err", {31'd0, ifc.stop_err}, 32'd0);
        check("glitch_p_data", {24'd0, ifc.P_DATA}, 32'h81);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(4);
`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-tick inversion at mid-bit of data bit 2 is outvoted.
        send_frame(8'h00, 1'b0, 1'b1, 2);
        idle(4);
`endif

        // Back-to-back frames, no idle gap between them.
        ifc.PRESCALE = 6'd8;
        send_frame(8'h55, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b0, 1'b1, -1);
        idle(4);

        // Reset in the middle of the data bits aborts the frame.
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rst_n     = 1'b0;
        ifc.RX_IN = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("midreset");
        rst_n     = 1'b1;
        last_good = 8'h00;
        idle(10);
        send_frame(8'h7E, 1'b0, 1'b1, -1);
        idle(20);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
